// File: rtl/attn_seq_ctrl.sv
// attn_seq_ctrl: sequences one Q.K attention pass on fullchip.
// Drives the registered 19-bit inst word and mem_in from a host vector stream.
module attn_seq_ctrl #(
  parameter int total_cycle = 8,
  parameter int col         = 8,
  parameter int pr          = 16,
  parameter int bw          = 8,
  parameter int gap_cycles  = 10,
  parameter int div_period  = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [pr*bw-1:0] in_data,
  output logic [pr*bw-1:0] mem_in,
  output logic [18:0]      inst,
  output logic             busy,
  output logic             done,
  output logic [3:0]       phase
);

  localparam int CW = 8;

  localparam int B_ACC  = 18;
  localparam int B_DIV  = 17;
  localparam int B_ORD  = 16;
  localparam int B_EXE  = 7;
  localparam int B_LOAD = 6;
  localparam int B_QRD  = 5;
  localparam int B_QWR  = 4;
  localparam int B_KRD  = 3;
  localparam int B_KWR  = 2;
  localparam int B_PRD  = 1;
  localparam int B_PWR  = 0;

  localparam logic [CW-1:0] TC_LAST =
    CW'(total_cycle - 1);
  localparam logic [CW-1:0] COL_N =
    CW'(col);
  localparam logic [CW-1:0] COL_LAST =
    CW'(col - 1);
  localparam logic [CW-1:0] COL_P1 =
    CW'(col + 1);
  localparam logic [CW-1:0] GAP_LAST =
    CW'(gap_cycles - 1);
  localparam logic [CW-1:0] DP_LAST =
    CW'(div_period - 1);

  typedef enum logic [3:0] {
    IDLE  = 4'd0,
    QWR   = 4'd1,
    KWR   = 4'd2,
    KLOAD = 4'd3,
    GAP1  = 4'd4,
    EXEC  = 4'd5,
    GAP2  = 4'd6,
    OFIFO = 4'd7,
    ACC   = 4'd8,
    DIV   = 4'd9,
    DONE  = 4'd10
  } state_t;

  state_t            state_q;
  logic [CW-1:0]     cnt_q;
  logic [CW-1:0]     sub_q;
  logic [18:0]       inst_q;
  logic [pr*bw-1:0]  mem_in_q;
  logic              done_q;
  logic [3:0]        am1;

  // KLOAD and ACC address one behind their cycle counter
  assign am1 = cnt_q[3:0] - 4'd1;

  assign in_ready = (state_q == QWR) ||
                    (state_q == KWR);
  assign busy     = (state_q != IDLE);
  assign phase    = state_q;
  assign inst     = inst_q;
  assign mem_in   = mem_in_q;
  assign done     = done_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      sub_q    <= '0;
      inst_q   <= '0;
      mem_in_q <= '0;
      done_q   <= 1'b0;
    end else begin
      inst_q <= '0;
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          cnt_q <= '0;
          sub_q <= '0;
          if (start) begin
            state_q <= QWR;
          end
        end
        QWR: begin
          if (in_valid) begin
            mem_in_q        <= in_data;
            inst_q[B_QWR]   <= 1'b1;
            inst_q[15:12]   <= cnt_q[3:0];
            if (cnt_q == TC_LAST) begin
              cnt_q   <= '0;
              state_q <= KWR;
            end else begin
              cnt_q <= cnt_q + CW'(1);
            end
          end
        end
        KWR: begin
          if (in_valid) begin
            mem_in_q        <= in_data;
            inst_q[B_KWR]   <= 1'b1;
            inst_q[15:12]   <= cnt_q[3:0];
            if (cnt_q == COL_LAST) begin
              cnt_q   <= '0;
              state_q <= KLOAD;
            end else begin
              cnt_q <= cnt_q + CW'(1);
            end
          end
        end
        KLOAD: begin
          inst_q[B_LOAD] <= 1'b1;
          if (cnt_q != '0 && cnt_q <= COL_N) begin
            inst_q[B_KRD] <= 1'b1;
            inst_q[15:12] <= am1;
          end
          if (cnt_q == COL_P1) begin
            cnt_q   <= '0;
            state_q <= GAP1;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        GAP1: begin
          if (cnt_q == GAP_LAST) begin
            cnt_q   <= '0;
            state_q <= EXEC;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        EXEC: begin
          inst_q[B_EXE] <= 1'b1;
          inst_q[B_QRD] <= 1'b1;
          inst_q[15:12] <= cnt_q[3:0];
          if (cnt_q == TC_LAST) begin
            cnt_q   <= '0;
            state_q <= GAP2;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        GAP2: begin
          if (cnt_q == GAP_LAST) begin
            cnt_q   <= '0;
            state_q <= OFIFO;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        OFIFO: begin
          inst_q[B_ORD] <= 1'b1;
          inst_q[B_PWR] <= 1'b1;
          inst_q[11:8]  <= cnt_q[3:0];
          if (cnt_q == TC_LAST) begin
            cnt_q   <= '0;
            state_q <= ACC;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        ACC: begin
          inst_q[B_ACC] <= 1'b1;
          if (cnt_q != '0) begin
            inst_q[B_PRD] <= 1'b1;
            inst_q[11:8]  <= am1;
          end
          if (cnt_q == COL_N) begin
            cnt_q   <= '0;
            sub_q   <= '0;
            state_q <= DIV;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        DIV: begin
          inst_q[B_PRD] <= 1'b1;
          inst_q[11:8]  <= cnt_q[3:0];
          if (sub_q == '0) begin
            inst_q[B_DIV] <= 1'b1;
          end
          if (sub_q == DP_LAST) begin
            sub_q <= '0;
            if (cnt_q == TC_LAST) begin
              cnt_q   <= '0;
              state_q <= DONE;
            end else begin
              cnt_q <= cnt_q + CW'(1);
            end
          end else begin
            sub_q <= sub_q + CW'(1);
          end
        end
        DONE: begin
          done_q  <= 1'b1;
          cnt_q   <= '0;
          state_q <= IDLE;
        end
        default: begin
          cnt_q   <= '0;
          sub_q   <= '0;
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_attn_seq_ctrl.sv
// tb_attn_seq_ctrl: random-data passes checked cycle by cycle
// against an expected trace built from the pass schedule.
module tb_attn_seq_ctrl;

  localparam int TC  = 8;
  localparam int COL = 8;
  localparam int GAP = 10;
  localparam int DP  = 3;
  localparam int W   = 16 * 8;

  logic         clk;
  logic         reset;
  logic         start;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic [W-1:0] mem_in;
  logic [18:0]  inst;
  logic         busy;
  logic         done;
  logic [3:0]   phase;

  int checks;
  int errors;

  attn_seq_ctrl dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .mem_in   (mem_in),
    .inst     (inst),
    .busy     (busy),
    .done     (done),
    .phase    (phase)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  logic [18:0]  e_inst[$];
  logic [W-1:0] e_mem[$];
  logic         e_done[$];
  logic [3:0]   e_ph[$];
  logic         d_val[$];
  logic         d_st[$];
  logic [W-1:0] d_dat[$];

  logic [W-1:0] qv[TC];
  logic [W-1:0] kv[COL];
  int           stl[TC+COL];
  logic [W-1:0] last_mem;
  int           done_edge;
  int           done_cnt;

  function automatic logic [W-1:0] rnd();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  function automatic logic [18:0] bw1(input int b);
    return 19'(1) << b;
  endfunction

  function automatic logic [18:0] qa(input int a);
    return 19'(a) << 12;
  endfunction

  function automatic logic [18:0] pa(input int a);
    return 19'(a) << 8;
  endfunction

  task automatic chk(input string tag,
                     input logic [W-1:0] obs,
                     input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // one scheduled edge: expected outputs plus what the host drives
  task automatic add(input logic [18:0] w, input logic [3:0] ph,
                     input logic v, input logic [W-1:0] dat,
                     input logic dn);
    e_inst.push_back(w);
    e_mem.push_back(last_mem);
    e_done.push_back(dn);
    e_ph.push_back(ph);
    d_val.push_back(v);
    d_dat.push_back(dat);
    d_st.push_back($urandom_range(0, 3) == 0);
  endtask

  task automatic build();
    logic [18:0] w;
    e_inst.delete(); e_mem.delete(); e_done.delete();
    e_ph.delete(); d_val.delete(); d_dat.delete(); d_st.delete();
    for (int i = 0; i < TC; i++) qv[i] = rnd();
    for (int i = 0; i < COL; i++) kv[i] = rnd();
    for (int i = 0; i < TC; i++) begin
      for (int s = 0; s < stl[i]; s++) add('0, 4'd1, 1'b0, rnd(), 1'b0);
      last_mem = qv[i];
      add(bw1(4) | qa(i), 4'd1, 1'b1, qv[i], 1'b0);
    end
    for (int i = 0; i < COL; i++) begin
      for (int s = 0; s < stl[TC+i]; s++) add('0, 4'd2, 1'b0, rnd(), 1'b0);
      last_mem = kv[i];
      add(bw1(2) | qa(i), 4'd2, 1'b1, kv[i], 1'b0);
    end
    for (int c = 0; c <= COL + 1; c++) begin
      w = bw1(6);
      if (c >= 1 && c <= COL) w = w | bw1(3) | qa(c - 1);
      add(w, 4'd3, 1'($urandom_range(0, 1)), rnd(), 1'b0);
    end
    for (int c = 0; c < GAP; c++)
      add('0, 4'd4, 1'($urandom_range(0, 1)), rnd(), 1'b0);
    for (int c = 0; c < TC; c++)
      add(bw1(7) | bw1(5) | qa(c), 4'd5, 1'b1, rnd(), 1'b0);
    for (int c = 0; c < GAP; c++)
      add('0, 4'd6, 1'($urandom_range(0, 1)), rnd(), 1'b0);
    for (int c = 0; c < TC; c++)
      add(bw1(16) | bw1(0) | pa(c), 4'd7, 1'b0, rnd(), 1'b0);
    for (int c = 0; c <= COL; c++) begin
      w = bw1(18);
      if (c >= 1) w = w | bw1(1) | pa(c - 1);
      add(w, 4'd8, 1'($urandom_range(0, 1)), rnd(), 1'b0);
    end
    for (int g = 0; g < TC; g++)
      for (int k = 0; k < DP; k++) begin
        w = bw1(1) | pa(g);
        if (k == 0) w = w | bw1(17);
        add(w, 4'd9, 1'($urandom_range(0, 1)), rnd(), 1'b0);
      end
    add('0, 4'd10, 1'($urandom_range(0, 1)), rnd(), 1'b1);
  endtask

  task automatic run_pass(input int abort_at);
    logic [3:0] nph;
    build();
    done_edge = 0;
    done_cnt  = 0;
    start    = 1'b1;
    in_valid = 1'b0;
    in_data  = rnd();
    @(posedge clk); #1;
    chk("start_phase", W'(phase), W'(e_ph[0]));
    chk("start_busy", W'(busy), W'(1'b1));
    for (int i = 0; i < e_inst.size(); i++) begin
      start    = d_st[i];
      in_valid = d_val[i];
      in_data  = d_dat[i];
      @(posedge clk); #1;
      nph = (i + 1 < e_inst.size()) ? e_ph[i+1] : 4'd0;
      chk($sformatf("inst@%0d", i + 1), W'(inst), W'(e_inst[i]));
      chk($sformatf("mem@%0d", i + 1), mem_in, e_mem[i]);
      chk($sformatf("done@%0d", i + 1), W'(done), W'(e_done[i]));
      chk($sformatf("phase@%0d", i + 1), W'(phase), W'(nph));
      chk($sformatf("busy@%0d", i + 1), W'(busy), W'(nph != 4'd0));
      chk($sformatf("rdy@%0d", i + 1), W'(in_ready),
          W'(nph == 4'd1 || nph == 4'd2));
      if (done) begin
        done_edge = i + 1;
        done_cnt++;
      end
      if (i + 1 == abort_at) return;
    end
    start    = 1'b0;
    in_valid = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      chk("idle_inst", W'(inst), '0);
      chk("idle_done", W'(done), '0);
      chk("idle_phase", W'(phase), '0);
    end
  endtask

  int sum;

  initial begin
    checks   = 0;
    errors   = 0;
    reset    = 1'b0;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    last_mem = '0;
    #12;
    chk("rst_inst", W'(inst), '0);
    chk("rst_mem", mem_in, '0);
    chk("rst_done", W'(done), '0);
    chk("rst_busy", W'(busy), '0);
    chk("rst_phase", W'(phase), '0);
    chk("rst_rdy", W'(in_ready), '0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;

    // zero-stall pass
    for (int i = 0; i < TC + COL; i++) stl[i] = 0;
    run_pass(0);
    chk("A_done_edge", W'(done_edge), W'(96));
    chk("A_done_cnt", W'(done_cnt), W'(1));

    // three-cycle stall before Q beat 4
    stl[4] = 3;
    run_pass(0);
    chk("B_done_edge", W'(done_edge), W'(99));
    chk("B_done_cnt", W'(done_cnt), W'(1));

    // random stalls over every beat
    sum = 0;
    for (int i = 0; i < TC + COL; i++) begin
      stl[i] = $urandom_range(0, 2);
      sum += stl[i];
    end
    run_pass(0);
    chk("C_done_edge", W'(done_edge), W'(96 + sum));
    chk("C_done_cnt", W'(done_cnt), W'(1));

    // reset while EXEC drives qkmem_add=3 (edge 40)
    for (int i = 0; i < TC + COL; i++) stl[i] = 0;
    run_pass(40);
    chk("abort_add", W'(inst[15:12]), W'(3));
    #2;
    reset = 1'b0;
    #1;
    last_mem = '0;
    chk("abort_inst", W'(inst), '0);
    chk("abort_busy", W'(busy), '0);
    chk("abort_mem", mem_in, '0);
    chk("abort_phase", W'(phase), '0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_phase", W'(phase), '0);
    run_pass(0);
    chk("D_done_edge", W'(done_edge), W'(96));
    chk("D_done_cnt", W'(done_cnt), W'(1));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
